// File: rtl/ring_fifo_pkg.sv
// Shared constants, width helper and status payload for the ring FIFO family.
package ring_fifo_pkg;

    localparam int unsigned FIFO_MODE_DROP      = 0;
    localparam int unsigned FIFO_MODE_OVERWRITE = 1;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;
    localparam logic DRST = 1'b0;

    // Address width of a power-of-two deep buffer.
    function automatic int unsigned fifo_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/ring_fifo_if.sv
// Producer/consumer bus of the ring FIFO; master drives requests, slave is the FIFO.
interface ring_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  clr;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

endinterface

// File: rtl/ring_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read, no reset so it maps to RAM.
module ring_fifo_mem
    import ring_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned AW         = fifo_aw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Read returns the pre-write contents when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/ring_fifo.sv
// Ring FIFO top: wrap-bit pointers, accept logic, occupancy decode, sticky error flags.
module ring_fifo
    import ring_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned OVERWRITE  = FIFO_MODE_DROP,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic      clk,
    input  logic      rstb,
    ring_fifo_if.slave io_fifo
);

    localparam int unsigned AW    = fifo_aw(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam logic        OW_EN = (OVERWRITE == FIFO_MODE_OVERWRITE);

    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_rd_seen;

    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_drop_oldest;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic                  w_mem_wr;
    logic                  w_mem_rd;
    logic [DATA_WIDTH-1:0] w_mem_q;
    fifo_status_t          w_status;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == CW'(DEPTH));
    assign w_empty = (w_count == '0);

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    assign w_rd_acc      = io_fifo.rd_en && !w_empty;
    assign w_wr_acc      = io_fifo.wr_en && (!w_full || OW_EN || w_rd_acc);
    assign w_drop_oldest = w_wr_acc && w_full && !w_rd_acc;
    assign w_ovf_evt     = io_fifo.wr_en && w_full && !w_rd_acc;
    assign w_udf_evt     = io_fifo.rd_en && w_empty;

    assign w_mem_wr = w_wr_acc && !io_fifo.clr;
    assign w_mem_rd = w_rd_acc && !io_fifo.clr;

    // Pointers, read-valid pulse and sticky flags; clr outranks any request.
    always_ff @(posedge clk or negedge rstb) begin
        if (rstb == DRST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_valid  <= LOW;
            r_overflow  <= LOW;
            r_underflow <= LOW;
            r_rd_seen   <= LOW;
        end else if (io_fifo.clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_valid  <= LOW;
            r_overflow  <= LOW;
            r_underflow <= LOW;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (w_rd_acc || w_drop_oldest) begin
                r_rd_ptr <= r_rd_ptr + CW'(1);
            end
            if (w_rd_acc) begin
                r_rd_seen <= HIGH;
            end
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= r_overflow  | w_ovf_evt;
            r_underflow <= r_underflow | w_udf_evt;
        end
    end

    ring_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_wr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (io_fifo.wr_data),
        .i_rd_en   (w_mem_rd),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_mem_q)
    );

    always_comb begin
        w_status              = '0;
        w_status.full         = w_full;
        w_status.empty        = w_empty;
        w_status.almost_full  = (w_count >= CW'(AF_LEVEL));
        w_status.almost_empty = (w_count <= CW'(AE_LEVEL));
        w_status.overflow     = r_overflow;
        w_status.underflow    = r_underflow;
    end

    // The RAM read register has no reset, so present zero until the first real read.
    assign io_fifo.rd_data      = r_rd_seen ? w_mem_q : '0;
    assign io_fifo.rd_valid     = r_rd_valid;
    assign io_fifo.count        = w_count;
    assign io_fifo.full         = w_status.full;
    assign io_fifo.empty        = w_status.empty;
    assign io_fifo.almost_full  = w_status.almost_full;
    assign io_fifo.almost_empty = w_status.almost_empty;
    assign io_fifo.overflow     = w_status.overflow;
    assign io_fifo.underflow    = w_status.underflow;

endmodule
